// File: rtl/sm_imem_pkg.sv
// sm_imem_pkg: shared FSM states and constants for the schoolMIPS instruction-memory loader
package sm_imem_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;
  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam int BIDX_W = 2;
endpackage

// File: rtl/sm_imem_loader_if.sv
// sm_imem_loader_if: CPU fetch port, load control and byte stream of the instruction-memory loader
interface sm_imem_loader_if #(parameter int ADDR_WIDTH = 6);
  logic [31:0] imAddr;
  logic [31:0] imData;
  logic load_start;
  logic [ADDR_WIDTH:0] load_words;
  logic [7:0] byte_data;
  logic byte_valid;
  logic byte_ready;
  logic cpu_rst_n;
  logic load_busy;
  logic load_done;
  logic load_err;
  modport master (output imAddr, load_start, load_words, byte_data, byte_valid,
                  input imData, byte_ready, cpu_rst_n, load_busy, load_done, load_err);
  modport slave (input imAddr, load_start, load_words, byte_data, byte_valid,
                 output imData, byte_ready, cpu_rst_n, load_busy, load_done, load_err);
endinterface

// File: rtl/sm_imem_byte_packer.sv
// sm_imem_byte_packer: assembles four little-endian stream bytes into a 32-bit word
module sm_imem_byte_packer
  import sm_imem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);
  logic [BIDX_W-1:0] idx;
  logic [23:0] sh;
  // The fourth byte is presented combinationally so the word can be written in its own cycle
  assign word_valid = accept && &idx;
  assign word = {byte_data, sh};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      idx <= '0;
      sh <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (accept) begin
      idx <= idx + BIDX_W'(1);
      sh <= {byte_data, sh[23:8]};
    end
endmodule

// File: rtl/sm_imem_loader.sv
// sm_imem_loader: word-addressed program RAM for schoolMIPS, loaded from a byte stream while the CPU is held in reset
// Define SM_IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum word after the data words.
module sm_imem_loader
  import sm_imem_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter logic [15:0] BYTE_TIMEOUT = 16'd50000
) (
  input logic clk,
  input logic rst,
  sm_imem_loader_if.slave bus
);
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  state_t state, state_n;
  logic [31:0] ram [2**ADDR_WIDTH];
  logic [ADDR_WIDTH:0] ptr, words;
  logic [15:0] tmo;
  logic err, busy, start, zero_len, accept, timeout, last, word_valid, done_c, err_set;
  logic [31:0] word;
`ifdef SM_IMEM_LOADER_CHECKSUM_EN
  logic [31:0] csum;
`endif
  assign busy = state == LOAD || state == CHECK;
  assign start = bus.load_start && (state == IDLE || state == DONE);
  assign zero_len = bus.load_words == '0;
  assign accept = bus.byte_valid && busy;
  assign timeout = busy && !accept && BYTE_TIMEOUT != 16'd0 && tmo + 16'd1 == BYTE_TIMEOUT;
  assign last = ptr + (ADDR_WIDTH+1)'(1) == words;
  sm_imem_byte_packer u_packer (
    .clk(clk), .rst(rst), .clear(start || timeout), .accept(accept),
    .byte_data(bus.byte_data), .word_valid(word_valid), .word(word)
  );
  always_comb begin
    state_n = state;
    done_c = 1'b0;
    err_set = 1'b0;
    if (start) begin
      state_n = zero_len ? DONE : LOAD;
      done_c = zero_len;
    end else if (timeout) begin
      state_n = IDLE;
      err_set = 1'b1;
    end else if (word_valid && state == LOAD && last) begin
`ifdef SM_IMEM_LOADER_CHECKSUM_EN
      state_n = CHECK;
`else
      state_n = DONE;
      done_c = 1'b1;
`endif
    end
`ifdef SM_IMEM_LOADER_CHECKSUM_EN
    else if (word_valid && state == CHECK) begin
      state_n = word == csum ? DONE : IDLE;
      done_c = word == csum;
      err_set = word != csum;
    end
`endif
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      words <= '0;
      tmo <= '0;
      err <= 1'b0;
`ifdef SM_IMEM_LOADER_CHECKSUM_EN
      csum <= '0;
`endif
    end else begin
      state <= state_n;
      if (start) begin
        ptr <= '0;
        words <= bus.load_words > DEPTH ? DEPTH : bus.load_words;
        tmo <= '0;
        err <= 1'b0;
`ifdef SM_IMEM_LOADER_CHECKSUM_EN
        csum <= '0;
`endif
      end else begin
        if (err_set) err <= 1'b1;
        if (busy) tmo <= accept ? 16'd0 : tmo + 16'd1;
        if (word_valid && state == LOAD) begin
          ptr <= ptr + (ADDR_WIDTH+1)'(1);
`ifdef SM_IMEM_LOADER_CHECKSUM_EN
          csum <= csum ^ word;
`endif
        end
      end
    end
  always_ff @(posedge clk)
    if (word_valid && state == LOAD) ram[ptr[ADDR_WIDTH-1:0]] <= word;
  assign bus.imData = bus.imAddr[31:ADDR_WIDTH] == '0 ? ram[bus.imAddr[ADDR_WIDTH-1:0]] : NOP;
  assign bus.byte_ready = busy;
  assign bus.load_busy = busy;
  assign bus.load_done = done_c;
  assign bus.load_err = err;
  assign bus.cpu_rst_n = state == DONE && !bus.load_start;
endmodule
